// File: rtl/fft32_frame_ctrl_pkg.sv
// Shared constants and state encoding for the 32-point FFT frame sequencer.
package fft32_frame_ctrl_pkg;

    localparam int FRAME_LEN = 32;
    localparam int PAIRS     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PAD  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/fft_out_tagger.sv
// Output labeller: in-frame pair index, start/end-of-frame flags and frame number.
module fft_out_tagger
    import fft32_frame_ctrl_pkg::*;
#(
    parameter int frame_w = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               m_valid,
    input  logic               m_ready,
    output logic [3:0]         m_idx,
    output logic               m_sop,
    output logic               m_eop,
    output logic [frame_w-1:0] m_frame,
    output logic               eop_acc
);

    logic accept;

    assign accept  = m_valid & m_ready;
    assign m_sop   = (m_idx == 4'd0);
    assign m_eop   = (m_idx == 4'(PAIRS - 1));
    assign eop_acc = accept & m_eop;

    always_ff @(posedge CLK) begin
        if (RST) begin
            m_idx   <= '0;
            m_frame <= '0;
        end else if (accept) begin
            m_idx <= m_idx + 4'd1;
            if (m_eop)
                m_frame <= m_frame + 1'b1;
        end
    end

endmodule

// File: rtl/fft32_frame_ctrl.sv
// Frames a valid/ready sample stream into 32-sample FFT frames, owns the pipeline
// clock-enable and tags the result pairs on the way out.
module fft32_frame_ctrl
    import fft32_frame_ctrl_pkg::*;
#(
    parameter int width        = 8,
    parameter int max_inflight = 4,
    parameter int frame_w      = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [width-1:0]   s_re,
    input  logic [width-1:0]   s_im,
    input  logic               s_last,
    output logic               fft_ce,
    output logic               fft_valid,
    output logic [width-1:0]   fft_ar,
    output logic [width-1:0]   fft_ai,
    input  logic               fft_valid_o,
    input  logic [width-1:0]   fft_xr,
    input  logic [width-1:0]   fft_xi,
    input  logic [width-1:0]   fft_yr,
    input  logic [width-1:0]   fft_yi,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [width-1:0]   m_xr,
    output logic [width-1:0]   m_xi,
    output logic [width-1:0]   m_yr,
    output logic [width-1:0]   m_yi,
    output logic [3:0]         m_idx,
    output logic               m_sop,
    output logic               m_eop,
    output logic [frame_w-1:0] m_frame,
    output logic               busy
);

    ctrl_state_e state;
    logic [4:0]  in_cnt;
    logic [3:0]  inflight;

    logic stall, at_limit, last_slot;
    logic inject_in, inject_pad, inject, drain;
    logic frame_done, eop_acc;

    // A full pipeline output that downstream refuses freezes everything.
    assign stall     = fft_valid_o & ~m_ready;
    assign at_limit  = (in_cnt == '0) & (inflight == 4'(max_inflight));
    assign last_slot = (in_cnt == 5'(FRAME_LEN - 1));

    assign s_ready    = ~stall & (state != ST_PAD) & ~at_limit;
    assign inject_in  = s_valid & s_ready & ~RST;
    assign inject_pad = (state == ST_PAD) & ~stall & ~RST;
    assign inject     = inject_in | inject_pad;
    assign frame_done = inject & last_slot;

    // Between frames with work still in the pipe, clock it with empty slots.
    assign drain = (state == ST_IDLE) & (in_cnt == '0) & (inflight != '0)
                 & ~inject_in & ~stall & ~RST;

    assign fft_ce    = inject | drain;
    assign fft_valid = inject;
    assign fft_ar    = inject_in ? s_re : '0;
    assign fft_ai    = inject_in ? s_im : '0;

    assign m_valid = fft_valid_o;
    assign m_xr    = fft_xr;
    assign m_xi    = fft_xi;
    assign m_yr    = fft_yr;
    assign m_yi    = fft_yi;

    assign busy = (inflight != '0) | (in_cnt != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            in_cnt   <= '0;
            inflight <= '0;
        end else begin
            if (inject)
                in_cnt <= in_cnt + 5'd1;

            case (state)
                ST_IDLE, ST_FILL: begin
                    if (inject_in) begin
                        if (last_slot)
                            state <= ST_IDLE;
                        else if (s_last)
                            state <= ST_PAD;
                        else
                            state <= ST_FILL;
                    end
                end
                ST_PAD: begin
                    if (inject_pad && last_slot)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (frame_done && !eop_acc)
                inflight <= inflight + 4'd1;
            else if (eop_acc && !frame_done)
                inflight <= inflight - 4'd1;
        end
    end

    fft_out_tagger #(
        .frame_w (frame_w)
    ) u_tagger (
        .CLK     (CLK),
        .RST     (RST),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_idx   (m_idx),
        .m_sop   (m_sop),
        .m_eop   (m_eop),
        .m_frame (m_frame),
        .eop_acc (eop_acc)
    );

endmodule

// File: tb/tb_fft32_frame_ctrl.sv
// Bench for fft32_frame_ctrl with a behavioural stand-in for the FFT pipeline
// (ce-clocked delay line emitting DFT pairs) and a frame-level scoreboard.
module tb_fft32_frame_ctrl;

    localparam int W = 8;
    localparam int D = 80;

    typedef int smp_t[32];
    typedef logic [31:0] pairs_t[16];
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic [7:0]  frm;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [W-1:0] s_re = '0, s_im = '0;
    logic         fft_ce, fft_valid;
    logic [W-1:0] fft_ar, fft_ai;
    logic         fft_valid_o;
    logic [W-1:0] fft_xr, fft_xi, fft_yr, fft_yi;
    logic         m_valid, m_ready = 1'b1;
    logic [W-1:0] m_xr, m_xi, m_yr, m_yi;
    logic [3:0]   m_idx;
    logic         m_sop, m_eop;
    logic [7:0]   m_frame;
    logic         busy;

    int   n_chk = 0, n_err = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t me;
    logic [7:0] exp_frm = '0;
    int   first_eop_cyc = -1;
    int   mval_cnt = 0;
    bit   rand_ready = 1'b0;
    bit   mr_fixed = 1'b1;

    fft32_frame_ctrl #(.width(W), .max_inflight(2), .frame_w(8)) dut (
        .CLK(CLK), .RST(RST),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_last(s_last),
        .fft_ce(fft_ce), .fft_valid(fft_valid), .fft_ar(fft_ar), .fft_ai(fft_ai),
        .fft_valid_o(fft_valid_o), .fft_xr(fft_xr), .fft_xi(fft_xi), .fft_yr(fft_yr), .fft_yi(fft_yi),
        .m_valid(m_valid), .m_ready(m_ready), .m_xr(m_xr), .m_xi(m_xi), .m_yr(m_yr), .m_yi(m_yi),
        .m_idx(m_idx), .m_sop(m_sop), .m_eop(m_eop), .m_frame(m_frame), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Plain DFT, X[k] = sum x[n] e^{-j2pi kn/32}, rounded and wrapped to 8 bits.
    // Pair j carries (X[j], X[j+16]).
    function automatic void dft(input smp_t re, input smp_t im, output pairs_t p);
        logic [7:0] xr[32];
        logic [7:0] xi[32];
        for (int k = 0; k < 32; k++) begin
            real ar, ai, ang;
            ar = 0.0;
            ai = 0.0;
            for (int n = 0; n < 32; n++) begin
                ang = -2.0 * 3.14159265358979 * real'((k * n) % 32) / 32.0;
                ar = ar + real'(re[n]) * $cos(ang) - real'(im[n]) * $sin(ang);
                ai = ai + real'(re[n]) * $sin(ang) + real'(im[n]) * $cos(ang);
            end
            xr[k] = 8'($rtoi(ar + ((ar >= 0.0) ? 0.5 : -0.5)));
            xi[k] = 8'($rtoi(ai + ((ai >= 0.0) ? 0.5 : -0.5)));
        end
        for (int j = 0; j < 16; j++)
            p[j] = {xr[j], xi[j], xr[j+16], xi[j+16]};
    endfunction

    function automatic logic [31:0] model_pair(input smp_t re, input smp_t im,
                                               input logic [7:0] lr, input logic [7:0] li,
                                               input int j);
        pairs_t p;
        re[31] = 32'($signed(lr));
        im[31] = 32'($signed(li));
        dft(re, im, p);
        return p[j];
    endfunction

    // Pipeline stand-in: advances only on fft_ce; a completed frame's pairs are
    // queued so the first one appears D-16 ce ticks after the 32nd sample.
    logic [32:0] pl[D];
    smp_t        pm_re, pm_im;
    int          pn;

    assign fft_valid_o = pl[0][32];
    assign {fft_xr, fft_xi, fft_yr, fft_yi} = pl[0][31:0];

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < D; i++) pl[i] <= '0;
            pn <= 0;
        end else if (fft_ce) begin
            for (int i = 0; i < D - 1; i++) pl[i] <= pl[i+1];
            pl[D-1] <= '0;
            if (fft_valid) begin
                pm_re[pn] <= 32'($signed(fft_ar));
                pm_im[pn] <= 32'($signed(fft_ai));
                pn <= (pn == 31) ? 0 : pn + 1;
                if (pn == 31)
                    for (int j = 0; j < 16; j++)
                        pl[D-16+j] <= {1'b1, model_pair(pm_re, pm_im, fft_ar, fft_ai, j)};
            end
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        m_ready = rand_ready ? ($urandom_range(1) == 1) : mr_fixed;
    end

    // Output monitor: scoreboard and stall rule.
    initial forever begin
        @(negedge CLK);
        if (!RST) begin
            if (fft_valid_o && !m_ready) begin
                chk("stall_ce", 64'(fft_ce), 64'(0));
                chk("stall_rdy", 64'(s_ready), 64'(0));
            end
            if (m_valid && m_ready) begin
                mval_cnt++;
                chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    me = sb.pop_front();
                    chk("pair_data", 64'({m_xr, m_xi, m_yr, m_yi}), 64'(me.data));
                    chk("pair_tag", 64'({m_idx, m_sop, m_eop, m_frame}),
                        64'({me.idx, me.idx == 4'd0, me.idx == 4'd15, me.frm}));
                end
                if (m_eop && first_eop_cyc < 0) first_eop_cyc = cyc;
            end
        end
    end

    task automatic push(input int re, input int im, input bit last, output int acc_cyc);
        int t;
        bit acc;
        t = 0;
        s_valid = 1'b1;
        s_re = 8'(re);
        s_im = 8'(im);
        s_last = last;
        forever begin
            @(negedge CLK);
            acc = s_ready;
            @(posedge CLK);
            #1;
            if (acc) break;
            t++;
            if (t > 3000) begin
                chk("push_tmo", 64'(t), 64'(0));
                break;
            end
        end
        acc_cyc = cyc;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic bubble(input int n);
        repeat (n) begin
            @(negedge CLK);
            chk("bubble_ce", 64'(fft_ce), 64'(0));
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input smp_t re, input smp_t im, input int n,
                              input bit last32, input int bub, output int first_acc);
        smp_t fr, fi;
        pairs_t p;
        int c;
        for (int i = 0; i < 32; i++) begin
            fr[i] = (i < n) ? re[i] : 0;
            fi[i] = (i < n) ? im[i] : 0;
        end
        dft(fr, fi, p);
        for (int j = 0; j < 16; j++)
            sb.push_back('{data: p[j], idx: 4'(j), frm: exp_frm});
        exp_frm++;
        first_acc = 0;
        for (int i = 0; i < n; i++) begin
            push(re[i], im[i], (i == n - 1) && (n < 32 || last32), c);
            if (i == 0) first_acc = c;
            if (bub > 0 && i % 3 == 2 && i < n - 1) bubble(bub);
        end
    endtask

    task automatic rand_frame(output smp_t re, output smp_t im);
        for (int i = 0; i < 32; i++) begin
            re[i] = int'($urandom_range(4)) - 2;
            im[i] = int'($urandom_range(4)) - 2;
        end
    endtask

    task automatic wait_idle(input int maxc, input bit drain_chk);
        int t;
        t = 0;
        forever begin
            @(negedge CLK);
            if (!busy) break;
            if (drain_chk) chk("drain_ce", 64'(fft_ce), 64'(1));
            t++;
            if (t > maxc) begin
                chk("idle_tmo", 64'(busy), 64'(0));
                break;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        smp_t re, im;
        int c0, c1;

        // Reset held with a sample pending
        RST = 1'b1;
        s_valid = 1'b1;
        s_re = 8'h5a;
        s_im = 8'h33;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_s_ready", 64'(s_ready), 64'(1));
        chk("rst_fft_ce", 64'(fft_ce), 64'(0));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        s_valid = 1'b0;
        @(negedge CLK);
        chk("post_rst_s_ready", 64'(s_ready), 64'(1));
        chk("post_rst_fft_ce", 64'(fft_ce), 64'(0));
        chk("post_rst_fft_valid", 64'(fft_valid), 64'(0));
        chk("post_rst_fft_a", 64'({fft_ar, fft_ai}), 64'(0));
        chk("post_rst_m_frame", 64'(m_frame), 64'(0));
        chk("post_rst_m_idx", 64'(m_idx), 64'(0));
        chk("post_rst_busy", 64'(busy), 64'(0));
        @(posedge CLK);
        #1;

        // Impulse
        for (int i = 0; i < 32; i++) begin
            re[i] = (i == 0) ? 1 : 0;
            im[i] = 0;
        end
        send_frame(re, im, 32, 1'b0, 0, c0);
        wait_idle(400, 1'b0);
        chk("impulse_m_frame", 64'(m_frame), 64'(1));

        // Short DC frame: 10 x (4,0), then 22 zero pads
        for (int i = 0; i < 32; i++) begin
            re[i] = 4;
            im[i] = 0;
        end
        send_frame(re, im, 10, 1'b0, 0, c0);
        repeat (22) begin
            @(negedge CLK);
            chk("pad_s_ready", 64'(s_ready), 64'(0));
            chk("pad_valid", 64'(fft_valid & fft_ce), 64'(1));
            chk("pad_zero", 64'({fft_ar, fft_ai}), 64'(0));
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        chk("pad_done_s_ready", 64'(s_ready), 64'(1));
        chk("pad_done_valid", 64'(fft_valid), 64'(0));
        wait_idle(400, 1'b0);
        chk("pad_inflight0", 64'(busy), 64'(0));

        // Random back-pressure: tone, random, random with s_last on sample 32
        rand_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            re[i] = $rtoi(2.0 * $cos(2.0 * 3.14159265358979 * 5.0 * real'(i) / 32.0) + 2.5) - 2;
            im[i] = $rtoi(2.0 * $sin(2.0 * 3.14159265358979 * 5.0 * real'(i) / 32.0) + 2.5) - 2;
        end
        send_frame(re, im, 32, 1'b0, 0, c0);
        rand_frame(re, im);
        send_frame(re, im, 32, 1'b0, 0, c0);
        rand_frame(re, im);
        send_frame(re, im, 32, 1'b1, 0, c0);
        rand_frame(re, im);
        send_frame(re, im, 32, 1'b0, 0, c0);
        wait_idle(3000, 1'b0);
        rand_ready = 1'b0;
        mr_fixed = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Inflight limit with downstream blocked
        rand_frame(re, im);
        send_frame(re, im, 32, 1'b0, 0, c0);
        rand_frame(re, im);
        send_frame(re, im, 32, 1'b0, 0, c0);
        s_valid = 1'b1;
        repeat (8) begin
            @(negedge CLK);
            chk("limit_s_ready", 64'(s_ready), 64'(0));
            chk("limit_busy", 64'(busy), 64'(1));
            @(posedge CLK);
            #1;
        end
        s_valid = 1'b0;
        first_eop_cyc = -1;
        mr_fixed = 1'b1;
        rand_frame(re, im);
        send_frame(re, im, 32, 1'b0, 0, c1);
        chk("limit_after_eop", 64'((first_eop_cyc >= 0) && (c1 > first_eop_cyc + 1)), 64'(1));
        wait_idle(1000, 1'b0);

        // Bubbles every 3 samples, then drain
        rand_frame(re, im);
        send_frame(re, im, 32, 1'b0, 3, c0);
        wait_idle(1000, 1'b1);
        chk("drain_busy", 64'(busy), 64'(0));

        // Reset in the middle of a frame
        rand_frame(re, im);
        for (int i = 0; i < 17; i++) push(re[i], im[i], 1'b0, c0);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_frm = '0;
        mval_cnt = 0;
        @(negedge CLK);
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_m_frame", 64'(m_frame), 64'(0));
        repeat (150) @(posedge CLK);
        #1;
        chk("midrst_no_output", 64'(mval_cnt), 64'(0));
        rand_frame(re, im);
        send_frame(re, im, 32, 1'b0, 0, c0);
        wait_idle(400, 1'b0);
        chk("midrst_m_frame_after", 64'(m_frame), 64'(1));
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
